// File: rtl/qdec.sv
// Quadrature encoder decoder for one motor channel.
// Synchronises and glitch-filters the A/B lines, x4-decodes them into a
// wrapping signed position count, and reports velocity as net counts per
// fixed window of WIN_CYCLES clocks. Illegal (double-bit) transitions raise
// a sticky err flag.
module qdec #(
    parameter int CNT_W      = 16,
    parameter int VEL_W      = 13,
    parameter int WIN_CYCLES = 1000000,
    parameter int FILT       = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    pos_clr,
    input  logic                    err_clr,
    output logic signed [CNT_W-1:0] pos,
    output logic signed [VEL_W-1:0] vel,
    output logic                    vel_valid,
    output logic                    dir,
    output logic                    err
);

    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int WW = $clog2(WIN_CYCLES);
    localparam int PW = $clog2(FILT + 3);
    localparam int AW = VEL_W + 2;

    // Clamp limits, held one bit wider than the accumulator so that a sum
    // can be compared before it is narrowed.
    localparam logic signed [AW:0] ACC_MAX = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [AW:0] VEL_MAX = {4'b0000, {(VEL_W-1){1'b1}}};
    localparam logic signed [AW:0] VEL_MIN = -VEL_MAX;

    // Bit 1 is channel A, bit 0 is channel B throughout.
    logic [1:0]        s1;
    logic [1:0]        s2;
    logic [1:0]        filt;
    logic [FW-1:0]     cnt [2];
    logic [1:0]        prev;
    logic              primed;
    logic [PW-1:0]     prime_cnt;
    logic              quiet;
    logic              fwd;
    logic              rev;
    logic              ill;
    logic signed [1:0] step;
    logic [WW-1:0]     win;
    logic signed [AW-1:0] acc;
    logic signed [AW:0]   acc_sum;
    logic signed [AW:0]   acc_clamp;
    logic signed [AW:0]   vel_clamp;

    // Two-flop synchroniser on both encoder lines.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // flops sample their inputs from before the edge, as real hardware does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {enc_a, enc_b};
            s2 <= s1;
        end
    end

    // Per-channel filter: accept a new level only after FILT agreeing samples.
    // NOTE: cnt is a two-entry register array, not a RAM, so it is reset
    // along with every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == FW'(FILT - 1)) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + FW'(1);
                end
            end
        end
    end

    // The input path has settled once synchroniser and filter agree.
    assign quiet = (s1 == s2) && (s2 == filt);

    // Classify the transition from prev to filt into a signed step.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        fwd  = 1'b0;
        rev  = 1'b0;
        ill  = 1'b0;
        step = 2'sb00;
        if (primed) begin
            case ({prev, filt})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
                4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill = 1'b1;
                default: ;
            endcase
        end
        if (fwd) begin
            step = 2'sb01;
        end else if (rev) begin
            step = 2'sb11;
        end
    end

    // Priming, position, direction and error state.
    // Priming holds until the synchroniser and filter have caught up with the
    // resting encoder level after reset, so a non-00 rest never counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev      <= '0;
            primed    <= 1'b0;
            prime_cnt <= '0;
            pos       <= '0;
            dir       <= 1'b0;
            err       <= 1'b0;
        end else begin
            prev <= filt;
            if (!primed) begin
                if (prime_cnt == PW'(FILT + 2)) begin
                    if (quiet) primed <= 1'b1;
                end else begin
                    prime_cnt <= prime_cnt + PW'(1);
                end
            end
            if (pos_clr) begin
                pos <= '0;
            end else if (fwd) begin
                pos <= pos + CNT_W'(1);
            end else if (rev) begin
                pos <= pos - CNT_W'(1);
            end
            if (fwd) begin
                dir <= 1'b1;
            end else if (rev) begin
                dir <= 1'b0;
            end
            if (ill) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // Next accumulator value and window result, both saturated.
    always_comb begin
        acc_sum   = {acc[AW-1], acc} + {{(AW-1){step[1]}}, step};
        acc_clamp = acc_sum;
        vel_clamp = acc_sum;
        if (acc_sum > ACC_MAX) begin
            acc_clamp = ACC_MAX;
        end else if (acc_sum < ACC_MIN) begin
            acc_clamp = ACC_MIN;
        end
        if (acc_sum > VEL_MAX) begin
            vel_clamp = VEL_MAX;
        end else if (acc_sum < VEL_MIN) begin
            vel_clamp = VEL_MIN;
        end
    end

    // Velocity window: accumulate steps, publish on the terminal cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win       <= '0;
            acc       <= '0;
            vel       <= '0;
            vel_valid <= 1'b0;
        end else if (win == WW'(WIN_CYCLES - 1)) begin
            win       <= '0;
            acc       <= '0;
            vel       <= vel_clamp[VEL_W-1:0];
            vel_valid <= 1'b1;
        end else begin
            win       <= win + WW'(1);
            acc       <= acc_clamp[AW-1:0];
            vel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qdec.sv
// Directed bench for qdec: reset values, x4 counting both ways, wrap,
// glitch rejection with exact latency, illegal transitions and err_clr,
// velocity windows (including saturation on a narrow instance), reset at a
// non-00 rest and pos_clr coincident with a step.
module tb_qdec;

    localparam int CNT_W = 16;
    localparam int VEL_W = 13;
    localparam int WIN   = 200;
    localparam int FILT  = 3;

    logic              clk;
    logic              rst_n;
    logic              enc_a;
    logic              enc_b;
    logic              pos_clr;
    logic              err_clr;
    logic [CNT_W-1:0]  pos;
    logic [VEL_W-1:0]  vel;
    logic              vel_valid;
    logic              dir;
    logic              err;
    logic [CNT_W-1:0]  pos2;
    logic [3:0]        vel2;
    logic              vel_valid2;
    logic              dir2;
    logic              err2;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int sq_cyc [$];
    int sq_vel [$];
    int last_vel2 = 0;

    logic [1:0] fseq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] rseq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

    qdec #(.CNT_W(CNT_W), .VEL_W(VEL_W), .WIN_CYCLES(WIN), .FILT(FILT)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .pos_clr(pos_clr), .err_clr(err_clr), .pos(pos), .vel(vel),
        .vel_valid(vel_valid), .dir(dir), .err(err)
    );

    qdec #(.CNT_W(CNT_W), .VEL_W(4), .WIN_CYCLES(WIN), .FILT(FILT)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .pos_clr(pos_clr), .err_clr(err_clr), .pos(pos2), .vel(vel2),
        .vel_valid(vel_valid2), .dir(dir2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    // Record every velocity strobe with the cycle it appeared on.
    always @(negedge clk) begin
        if (!rst_n) begin
            sq_cyc.delete();
            sq_vel.delete();
        end else begin
            if (vel_valid) begin
                sq_cyc.push_back(cyc);
                sq_vel.push_back(int'($signed(vel)));
            end
            if (vel_valid2) last_vel2 = int'($signed(vel2));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int qget(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -99999;
    endfunction

    task automatic drive(input logic [1:0] ab, input int hold);
        {enc_a, enc_b} = ab;
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        for (int g = 0; g < 5000 && cyc < n; g++) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        pos_clr = 1'b0;
        err_clr = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_pos", int'(pos), 0);
        check("rst_vel", int'(vel), 0);
        check("rst_vel_valid", int'(vel_valid), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;

        // Velocity: 10 forward in window 1, 3 reverse in window 2.
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10; i++) drive(fseq[i % 4], 8);
        wait_cyc(210);
        drive(2'b01, 8);
        drive(2'b00, 8);
        drive(2'b10, 8);
        wait_cyc(410);
        check("strobe_count", sq_cyc.size(), 2);
        check("strobe1_cycle", qget(sq_cyc, 0), 200);
        check("vel_win1", qget(sq_vel, 0), 10);
        check("strobe2_cycle", qget(sq_cyc, 1), 400);
        check("vel_win2", qget(sq_vel, 1), -3);

        // Forward rotation, reverse, clear, and wrap below zero.
        enc_a = 1'b0;
        enc_b = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 12; i++) drive(fseq[i % 4], 20);
        check("fwd_pos", int'(pos), 12);
        check("fwd_dir", int'(dir), 1);
        check("fwd_err", int'(err), 0);
        for (int i = 0; i < 8; i++) drive(rseq[i % 4], 20);
        check("rev_pos", int'(pos), 4);
        check("rev_dir", int'(dir), 0);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        check("pos_clr", int'(pos), 0);
        for (int i = 0; i < 17; i++) drive(rseq[i % 4], 8);
        drive(rseq[0], 12);
        check("wrap_pos", int'(pos), 32'hFFEF);

        // Glitch rejection from AB=01 (A rising is a forward step there).
        drive(2'b00, 20);
        drive(2'b01, 20);
        check("pre_glitch_pos", int'(pos), 32'hFFF1);
        enc_a = 1'b1;
        repeat (2) @(negedge clk);
        enc_a = 1'b0;
        repeat (15) @(negedge clk);
        check("glitch2_pos", int'(pos), 32'hFFF1);
        check("glitch2_err", int'(err), 0);
        enc_a = 1'b1;
        repeat (3) @(negedge clk);
        enc_a = 1'b0;
        repeat (2) @(negedge clk);
        check("glitch3_before", int'(pos), 32'hFFF1);
        @(negedge clk);
        check("glitch3_at_lat", int'(pos), 32'hFFF2);
        repeat (15) @(negedge clk);
        check("glitch3_back", int'(pos), 32'hFFF1);

        // Illegal jumps and err_clr.
        drive(2'b00, 20);
        drive(2'b11, 20);
        check("ill_err", int'(err), 1);
        check("ill_pos", int'(pos), 32'hFFF0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", int'(err), 0);
        {enc_a, enc_b} = 2'b00;
        repeat (5) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_set_wins", int'(err), 1);

        // Reset while resting at AB=11, then pos_clr against a step.
        drive(2'b11, 20);
        do_reset();
        repeat (20) @(negedge clk);
        check("rst11_pos", int'(pos), 0);
        check("rst11_err", int'(err), 0);
        {enc_a, enc_b} = 2'b10;
        repeat (5) @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        check("clr_step_pos", int'(pos), 0);
        check("clr_step_dir", int'(dir), 1);
        drive(2'b10, 15);
        drive(2'b00, 20);
        check("after_clr_pos", int'(pos), 1);
        wait_cyc(210);
        check("clr_win_vel", qget(sq_vel, 0), 2);

        // 20 forward steps in one window: full and 4-bit saturating velocity.
        wait_cyc(205);
        for (int i = 0; i < 20; i++) drive(fseq[i % 4], 6);
        wait_cyc(410);
        check("win20_cycle", qget(sq_cyc, 1), 400);
        check("win20_vel", qget(sq_vel, 1), 20);
        check("win20_vel_sat", last_vel2, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/qdec.md
# qdec

Quadrature encoder decoder for one motor channel: the feedback path returning from the H-bridge motors that the PWM/direction logic drives. Synchronises and glitch-filters the encoder A/B lines, performs x4 decoding into a wrapping signed position counter, and measures velocity as net counts per fixed window. One instance per motor; the outputs feed closed-loop speed control that sets PWM duty.

## Interface
- CNT_W, 16: position counter width (two's complement, wraps).
- VEL_W, 13: velocity output width (signed, saturating).
- WIN_CYCLES, 1000000: velocity window length in clk cycles (≥2).
- FILT, 3: consecutive identical samples needed to accept an input level (≥1).

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enc_a  in  1  encoder channel A, asynchronous.
- enc_b  in  1  encoder channel B, asynchronous.
- pos_clr  in  1  single-cycle pulse: zero position.
- err_clr  in  1  single-cycle pulse: clear err.
- pos  out  CNT_W  signed position count.
- vel  out  VEL_W  signed counts in last completed window.
- vel_valid  out  1  one-cycle strobe when vel updates.
- dir  out  1  direction of last valid step (1 = forward).
- err  out  1  sticky illegal-transition flag.

## Operation
- Sync: each channel through 2 flops (s1, s2).
- Filter per channel: counter cnt. If s2 == filt: cnt <= 0. Else if cnt == FILT-1: filt <= s2, cnt <= 0. Else cnt <= cnt+1.
- Decode on {filt_a, filt_b} vs previous {prev_a, prev_b}, registered each cycle:
  - forward (+1): 00→01, 01→11, 11→10, 10→00.
  - reverse (−1): reverse of the above.
  - unchanged: no step.
  - both bits changed: no step, err <= 1.
- Priming: after reset, the `primed` flag is 0. While `primed` is 0, filtered state is copied to prev without counting, and `primed` sets. This prevents a spurious step when the encoder rests at a non-00 state.
- pos: pos <= pos + step, modulo 2^CNT_W (0x7FFF+1 → 0x8000 at default width).
- pos_clr: pos <= 0 and that cycle's step is discarded. A step one cycle later counts from 0.
- dir: updated on each valid step and held otherwise.
- err: set by an illegal transition and cleared by err_clr. If both occur in the same cycle, set wins.
- Velocity:
  - Window counter runs 0..WIN_CYCLES-1 and wraps.
  - Accumulator acc (VEL_W+2 bits) sums steps.
  - On the terminal count: vel <= sat(acc + step), acc <= 0, vel_valid <= 1.
  - sat clamps to ±(2^(VEL_W-1)−1).
  - acc also saturates internally rather than wrapping.
  - pos_clr does not affect acc or the window.

## Timing
- Reset values (rst_n low at a rising edge):
  - Outputs: pos=0, vel=0, vel_valid=0, dir=0, err=0.
  - Internal: s1/s2/filt/prev=0, cnt=0, primed=0, window=0, acc=0.
- Latency:
  - Edge E0 is the first rising edge that samples a new input level.
  - filt changes at E0+FILT+1.
  - pos/dir/err/acc update at E0+FILT+2.
  - With FILT=3, this is 5 cycles after E0.
- Glitch rejection: a level held for fewer than FILT consecutive s2 samples is discarded.
- Step rate: at most one step per FILT+1 cycles per channel. Faster encoder rates are out of spec and may raise err.
- vel_valid:
  - High exactly one cycle, every WIN_CYCLES cycles.
  - First strobe is WIN_CYCLES cycles after reset release.
  - A step landing on the terminal cycle is included in that window.
- Reset mid-operation: all state returns to reset values on that edge. The priming step repeats after release, so no count is generated from the resting encoder state.

## Test plan
- Forward rotation: from 00, drive AB 01,11,10,00 with each level held 20 cycles, repeated 3 times → pos=12, dir=1, err=0.
- Reverse: from pos=12, drive 10,11,01,00 ×2 → pos=4, dir=0.
  - Then drive 17 reverse steps from pos=0 → pos=0xFFEF.
- Glitch, FILT=3: pulse enc_a high for 2 cycles → pos unchanged.
  - Same pulse held for 3 cycles → pos +1 (timing per Latency, FILT=3).
- Illegal jump: 00→11 → err=1, pos unchanged.
  - err_clr → err=0.
  - err_clr in the same cycle as a new illegal jump → err stays 1.
- Velocity, WIN_CYCLES=200: 10 forward steps in the first window, 3 reverse in the second.
  - vel_valid strobes at cycles 200 and 400 after reset release.
  - vel=10 after the first window, then vel=−3.
  - With VEL_W=4 and 20 steps in a window → vel=7.
- pos_clr and reset:
  - Resting at AB=11, assert rst_n low then release → pos stays 0.
  - pos_clr coincident with a forward step → pos=0.
  - Next step → pos=1.
  - vel for the window still counts both steps.
